// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg
//   Shared definitions for the audio FFT frame sequencer.
//   - Default frame geometry and frame-tick prescaler.
//   - Sequencer state encoding (IDLE, ACQ, START, XFORM, DONE).
//   - Helpers for the bin count (NBINS = FRAME_LEN/2) and counter widths.
package fft_seq_pkg;

    localparam int DEF_FRAME_LEN = 1024;
    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_PRESC     = 10_000_000;
    localparam int FRAME_CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACQ   = 3'd1,
        START = 3'd2,
        XFORM = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // A real FFT of FRAME_LEN samples yields FRAME_LEN/2 unique magnitude bins.
    function automatic int nbins_of(input int frame_len);
        return frame_len / 2;
    endfunction

    // Bits needed for a counter running 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen
//   Free-running frame-rate prescaler. The counter runs 0..PRESC-1 and
//   tick is high for the single cycle in which the counter holds PRESC-1.
//   Ports:
//     clk    in   system clock
//     reset  in   synchronous, active-high; restarts the count at 0
//     tick   out  one-cycle frame-rate pulse
module frame_tick_gen
    import fft_seq_pkg::*;
#(
    parameter int PRESC = DEF_PRESC
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int              CW   = cnt_width(PRESC);
    localparam logic [CW-1:0]   LAST = CW'(PRESC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Frame-level controller for the audio FFT datapath. Each frame tick
//   (unless frozen) acquires FRAME_LEN mic samples into the time buffer,
//   starts the FFT core, writes its NBINS magnitude bins into the frequency
//   buffer and reports completion / status to the PicoBlaze interface.
//   Optional feature macro: FFT_SEQ_PEAK_EN adds the peak-bin tracker
//   (peak_bin, peak_mag) and the clr_status input.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     sample_valid        one-cycle strobe per mic sample
//     freeze              level; no new frames start while high
//     frame_active        time-buffer enable (high in ACQ)
//     time_we, time_addr  time-buffer write port
//     fft_start/fft_busy  FFT core start handshake
//     fft_dout_valid/_dout magnitude bin stream from the FFT core
//     freq_we/addr/din    frequency-buffer write port (1 cycle after a bin)
//     frame_done          one-cycle pulse per completed frame
//     frame_count         completed frames, wraps 0xFFFF -> 0
//     overrun, fft_err    sticky status flags
//     clr_status          (FFT_SEQ_PEAK_EN) clears overrun and fft_err
//     peak_bin, peak_mag  (FFT_SEQ_PEAK_EN) strongest non-DC bin of last frame
//     state_dbg           current sequencer state encoding
//
// FFT handshake: fft_start is a request level that stays high from entry
// into START until the first cycle the core reports fft_busy=1; the core's
// busy is the acknowledge. While busy, every fft_dout_valid cycle carries one
// bin with no back-pressure. busy falling before NBINS bins is an abort.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int PRESC     = DEF_PRESC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_valid,
    input  logic                   freeze,
    output logic                   frame_active,
    output logic                   time_we,
    output logic [ADDR_W-1:0]      time_addr,
    output logic                   fft_start,
    input  logic                   fft_busy,
    input  logic                   fft_dout_valid,
    input  logic [DATA_W-1:0]      fft_dout,
    output logic                   freq_we,
    output logic [ADDR_W-1:0]      freq_addr,
    output logic [DATA_W-1:0]      freq_din,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   overrun,
    output logic                   fft_err,
`ifdef FFT_SEQ_PEAK_EN
    input  logic                   clr_status,
    output logic [ADDR_W-1:0]      peak_bin,
    output logic [DATA_W-1:0]      peak_mag,
`endif
    output logic [2:0]             state_dbg
);

    localparam int                NBINS       = nbins_of(FRAME_LEN);
    localparam logic [ADDR_W-1:0] LAST_SAMPLE = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_BIN    = ADDR_W'(NBINS - 1);

    seq_state_t        state, state_nxt;
    logic              tick;
    logic [ADDR_W-1:0] bin_cnt;     // bins accepted so far this frame
    logic              bin_accept;  // a bin is taken this cycle
    logic              last_bin;    // the bin taken this cycle is the final one
    logic              abort;       // core dropped busy with bins outstanding
    logic              enter_xform;

    frame_tick_gen #(
        .PRESC (PRESC)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign state_dbg   = state;
    assign enter_xform = (state == START) && (state_nxt == XFORM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        frame_active = 1'b0;
        time_we      = 1'b0;
        fft_start    = 1'b0;
        frame_done   = 1'b0;
        bin_accept   = 1'b0;
        last_bin     = 1'b0;
        abort        = 1'b0;
        case (state)
            IDLE: begin
                // freeze only gates the start of a frame; a running frame finishes.
                if (tick && !freeze) begin
                    state_nxt = ACQ;
                end
            end
            ACQ: begin
                frame_active = 1'b1;
                time_we      = sample_valid;
                if (sample_valid && (time_addr == LAST_SAMPLE)) begin
                    state_nxt = START;
                end
            end
            START: begin
                fft_start = 1'b1;
                if (fft_busy) begin
                    state_nxt = XFORM;
                end
            end
            XFORM: begin
                if (fft_dout_valid) begin
                    bin_accept = 1'b1;
                    last_bin   = (bin_cnt == LAST_BIN);
                end
                // A final bin arriving together with busy falling is a clean finish.
                if (last_bin) begin
                    state_nxt = DONE;
                end else if (!fft_busy) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_addr   <= '0;
            bin_cnt     <= '0;
            freq_we     <= 1'b0;
            freq_addr   <= '0;
            freq_din    <= '0;
            frame_count <= '0;
            overrun     <= 1'b0;
            fft_err     <= 1'b0;
        end else begin
            // Address wraps to 0 on its own after the FRAME_LEN-1 write.
            if ((state == IDLE) && (state_nxt == ACQ)) begin
                time_addr <= '0;
            end else if (time_we) begin
                time_addr <= time_addr + 1'b1;
            end

            // Bins are registered, so the buffer write trails dout_valid by one cycle;
            // freq_addr holds the address of the most recent write.
            freq_we <= bin_accept;
            if (enter_xform) begin
                bin_cnt   <= '0;
                freq_addr <= '0;
            end else if (bin_accept) begin
                freq_addr <= bin_cnt;
                freq_din  <= fft_dout;
                bin_cnt   <= bin_cnt + 1'b1;
            end

            if (frame_done) begin
                frame_count <= frame_count + 1'b1;
            end

`ifdef FFT_SEQ_PEAK_EN
            if (clr_status) begin
                overrun <= 1'b0;
                fft_err <= 1'b0;
            end
`endif
            // Setting events take precedence over a simultaneous clear.
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            if (abort) begin
                fft_err <= 1'b1;
            end
        end
    end

`ifdef FFT_SEQ_PEAK_EN
    logic [ADDR_W-1:0] run_bin;
    logic [DATA_W-1:0] run_mag;

    // Running max over bins 1..NBINS-1; strict compare keeps the lower bin on ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_bin  <= '0;
            run_mag  <= '0;
            peak_bin <= '0;
            peak_mag <= '0;
        end else begin
            if (enter_xform) begin
                run_bin <= '0;
                run_mag <= '0;
            end else if (bin_accept && (bin_cnt != '0) && (fft_dout > run_mag)) begin
                run_bin <= bin_cnt;
                run_mag <= fft_dout;
            end
            if (frame_done) begin
                peak_bin <= run_bin;
                peak_mag <= run_mag;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer
//   Self-checking bench for fft_frame_sequencer with FRAME_LEN=16, PRESC=200.
//   Table of frame scenarios plus hand-written sequences for freeze,
//   reset mid-acquisition and (with FFT_SEQ_PEAK_EN) the peak tracker.
module tb_fft_frame_sequencer;
    import fft_seq_pkg::*;

    localparam int FL = 16;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int PR = 200;
    localparam int NB = FL / 2;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sample_valid = 1'b0;
    logic          freeze = 1'b0;
    logic          fft_busy = 1'b0;
    logic          fft_dout_valid = 1'b0;
    logic [DW-1:0] fft_dout = '0;
    logic          frame_active, time_we, fft_start, freq_we, frame_done;
    logic          overrun, fft_err;
    logic [AW-1:0] time_addr, freq_addr;
    logic [DW-1:0] freq_din;
    logic [15:0]   frame_count;
    logic [2:0]    state_dbg;
`ifdef FFT_SEQ_PEAK_EN
    logic          clr_status = 1'b0;
    logic [AW-1:0] peak_bin;
    logic [DW-1:0] peak_mag;
`endif

    always #5 clk = ~clk;

    fft_frame_sequencer #(
        .FRAME_LEN (FL),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .PRESC     (PR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .freeze         (freeze),
        .frame_active   (frame_active),
        .time_we        (time_we),
        .time_addr      (time_addr),
        .fft_start      (fft_start),
        .fft_busy       (fft_busy),
        .fft_dout_valid (fft_dout_valid),
        .fft_dout       (fft_dout),
        .freq_we        (freq_we),
        .freq_addr      (freq_addr),
        .freq_din       (freq_din),
        .frame_done     (frame_done),
        .frame_count    (frame_count),
        .overrun        (overrun),
        .fft_err        (fft_err),
`ifdef FFT_SEQ_PEAK_EN
        .clr_status     (clr_status),
        .peak_bin       (peak_bin),
        .peak_mag       (peak_mag),
`endif
        .state_dbg      (state_dbg)
    );

    // Cycle index since the last reset edge; matches the prescaler phase.
    logic [31:0] cyc = '0;
    always @(posedge clk) cyc <= reset ? 32'd0 : cyc + 32'd1;

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    int          done_seen = 0;
    int          act_cycles = 0;
    logic [31:0] time_q[$];   // {cycle, addr}
    logic [31:0] freq_q[$];   // {cycle, addr, data}
    logic [31:0] mon_e;
    logic [7:0]  bins_data [0:9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (time_we) begin
            if (time_q.size() == 0) begin
                check("time_we_unexpected", {31'd0, time_we}, 32'd0);
            end else begin
                mon_e = time_q.pop_front();
                check("time_write", {cyc[15:0], 12'd0, time_addr}, mon_e);
            end
        end
        if (freq_we) begin
            if (freq_q.size() == 0) begin
                check("freq_we_unexpected", {31'd0, freq_we}, 32'd0);
            end else begin
                mon_e = freq_q.pop_front();
                check("freq_write", {cyc[15:0], 4'd0, freq_addr, freq_din}, mon_e);
            end
        end
        if (frame_done) done_seen++;
        if (frame_active) act_cycles++;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        reset          = 1'b1;
        sample_valid   = 1'b0;
        fft_busy       = 1'b0;
        fft_dout_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        time_q.delete();
        freq_q.delete();
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_flags"}, {25'd0, frame_active, time_we, fft_start, freq_we,
                               frame_done, overrun, fft_err}, 32'd0);
        check({tag, "_time_addr"}, {28'd0, time_addr}, 32'd0);
        check({tag, "_freq_port"}, {20'd0, freq_addr, freq_din}, 32'd0);
        check({tag, "_frame_count"}, {16'd0, frame_count}, 32'd0);
        check({tag, "_state"}, {29'd0, state_dbg}, {29'd0, IDLE});
`ifdef FFT_SEQ_PEAK_EN
        check({tag, "_peak"}, {20'd0, peak_bin, peak_mag}, 32'd0);
`endif
    endtask

    task automatic wait_active(output bit ok);
        int t;
        t = 0;
        @(negedge clk);
        while (!frame_active && t < 1000) begin
            @(negedge clk);
            t++;
        end
        ok = frame_active;
        check("acq_seen", {31'd0, frame_active}, 32'd1);
        if (ok) check("acq_tick_align", cyc % PR, 32'd0);
    endtask

    task automatic run_frame(input int gap, input int busy_lat, input int nbins,
                             input int bin_gap, input bit freeze_mid);
        int d0;
        int t;
        bit ok;
        d0 = done_seen;
        wait_active(ok);
        if (!ok) return;
        if (freeze_mid) freeze = 1'b1;
        for (int i = 0; i < FL; i++) begin
            @(posedge clk); #1;
            sample_valid = 1'b1;
            time_q.push_back({cyc[15:0], 16'(i)});
            for (int g = 1; g < gap; g++) begin
                @(posedge clk); #1;
                sample_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;

        t = 0;
        @(negedge clk);
        while (!fft_start && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("start_seen", {31'd0, fft_start}, 32'd1);
        if (!fft_start) return;
        for (int k = 1; k < busy_lat; k++) begin
            @(negedge clk);
            check("start_hold", {31'd0, fft_start}, 32'd1);
        end
        @(posedge clk); #1;
        fft_busy = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < nbins; i++) begin
            fft_dout_valid = 1'b1;
            fft_dout       = bins_data[i];
            if (i < NB) freq_q.push_back({16'(cyc + 32'd1), 8'(i), bins_data[i]});
            if (i == 0) begin
                @(negedge clk);
                check("start_drop", {31'd0, fft_start}, 32'd0);
            end
            @(posedge clk); #1;
            fft_dout_valid = 1'b0;
            for (int g = 1; g < bin_gap; g++) begin
                @(posedge clk); #1;
            end
        end
        fft_busy = 1'b0;

        t = 0;
        while (done_seen == d0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("done_pulses", done_seen - d0, 32'd1);
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        int gap;        // clk per mic sample
        int busy_lat;   // cycles fft_start is seen before busy rises
        int nbins;      // dout_valid strobes sent while busy
        int bin_gap;    // clk per bin
        bit freeze_mid; // raise freeze once ACQ is seen
        bit exp_err;
        bit exp_ovr;
        int exp_last;   // freq_addr after the frame
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int a0;

        vecs[0] = '{gap:4,  busy_lat:3, nbins:8,  bin_gap:1, freeze_mid:1'b0, exp_err:1'b0, exp_ovr:1'b0, exp_last:7};
        vecs[1] = '{gap:1,  busy_lat:1, nbins:8,  bin_gap:3, freeze_mid:1'b0, exp_err:1'b0, exp_ovr:1'b0, exp_last:7};
        vecs[2] = '{gap:4,  busy_lat:5, nbins:10, bin_gap:1, freeze_mid:1'b0, exp_err:1'b0, exp_ovr:1'b0, exp_last:7};
        vecs[3] = '{gap:20, busy_lat:2, nbins:8,  bin_gap:1, freeze_mid:1'b0, exp_err:1'b0, exp_ovr:1'b1, exp_last:7};
        vecs[4] = '{gap:4,  busy_lat:2, nbins:5,  bin_gap:1, freeze_mid:1'b0, exp_err:1'b1, exp_ovr:1'b0, exp_last:4};
        vecs[5] = '{gap:2,  busy_lat:1, nbins:8,  bin_gap:2, freeze_mid:1'b1, exp_err:1'b0, exp_ovr:1'b0, exp_last:7};

        do_reset();
        check_idle("reset");

        for (int v = 0; v < 6; v++) begin
            freeze = 1'b0;
            do_reset();
            for (int j = 0; j < 10; j++) bins_data[j] = 8'($urandom_range(0, 255));
            run_frame(vecs[v].gap, vecs[v].busy_lat, vecs[v].nbins, vecs[v].bin_gap,
                      vecs[v].freeze_mid);
            check($sformatf("v%0d_fft_err", v), {31'd0, fft_err}, {31'd0, vecs[v].exp_err});
            check($sformatf("v%0d_overrun", v), {31'd0, overrun}, {31'd0, vecs[v].exp_ovr});
            check($sformatf("v%0d_freq_addr", v), {28'd0, freq_addr}, 32'(vecs[v].exp_last));
            check($sformatf("v%0d_frame_count", v), {16'd0, frame_count}, 32'd1);
            check($sformatf("v%0d_state", v), {29'd0, state_dbg}, {29'd0, IDLE});
            check($sformatf("v%0d_time_q_left", v), time_q.size(), 32'd0);
            check($sformatf("v%0d_freq_q_left", v), freq_q.size(), 32'd0);
        end

        // Freeze across three ticks: nothing starts, no overrun.
        freeze = 1'b0;
        do_reset();
        freeze = 1'b1;
        a0 = act_cycles;
        repeat (650) @(posedge clk);
        @(negedge clk);
        check("freeze_active_cycles", act_cycles - a0, 32'd0);
        check("freeze_overrun", {31'd0, overrun}, 32'd0);
        check("freeze_frame_count", {16'd0, frame_count}, 32'd0);
        freeze = 1'b0;

        // Reset during acquisition once time_addr reaches 7.
        do_reset();
        wait_active(ok);
        if (ok) begin
            for (int i = 0; i < 7; i++) begin
                @(posedge clk); #1;
                sample_valid = 1'b1;
                time_q.push_back({cyc[15:0], 16'(i)});
                @(posedge clk); #1;
                sample_valid = 1'b0;
            end
            @(negedge clk);
            check("mid_acq_time_addr", {28'd0, time_addr}, 32'd7);
            @(posedge clk); #1;
            reset = 1'b1;
            @(posedge clk); #1;
            check_idle("mid_acq_reset");
            @(posedge clk); #1;
            reset = 1'b0;
            for (int j = 0; j < 10; j++) bins_data[j] = 8'($urandom_range(0, 255));
            run_frame(4, 1, 8, 1, 1'b0);
            check("post_reset_frame_count", {16'd0, frame_count}, 32'd1);
            check("post_reset_queues", time_q.size() + freq_q.size(), 32'd0);
        end

`ifdef FFT_SEQ_PEAK_EN
        do_reset();
        bins_data = '{8'd9, 8'd3, 8'd50, 8'd50, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        run_frame(4, 1, 8, 1, 1'b0);
        check("peak_bin", {28'd0, peak_bin}, 32'd2);
        check("peak_mag", {24'd0, peak_mag}, 32'd50);

        do_reset();
        run_frame(20, 1, 8, 1, 1'b0);
        check("clr_pre_overrun", {31'd0, overrun}, 32'd1);
        @(posedge clk); #1;
        clr_status = 1'b1;
        @(posedge clk); #1;
        clr_status = 1'b0;
        @(negedge clk);
        check("clr_post_overrun", {31'd0, overrun}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
